// File: rtl/mask_bit_scan16.sv
// Sequential mask decoder: accepts a 16-bit word and emits the index of each
// set bit, lowest first, clearing one bit per output handshake.
module mask_bit_scan16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic [4:0]  bit_count,
    output logic        done
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_word;
    logic [4:0]  r_count;
    logic        r_done;

    logic [15:0] w_clear;
    logic [3:0]  w_lowIdx;
    logic [4:0]  w_popCount;
    logic        w_accept;
    logic        w_take;

    assign w_clear = r_word & (r_word - 16'd1);

    always_comb begin
        w_lowIdx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_word[i]) begin
                w_lowIdx = 4'(i);
            end
        end
    end

    always_comb begin
        w_popCount = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_popCount = w_popCount + 5'(in_word[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Handshake flags depend only on state, never on in_valid/out_ready.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        w_accept    = 1'b0;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid && (in_word != 16'd0)) begin
                    w_nextState = SCAN;
                end
            end
            SCAN: begin
                out_valid = 1'b1;
                out_last  = (w_clear == 16'd0);
                w_take    = out_ready;
                if (out_ready && (w_clear == 16'd0)) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= 16'd0;
            r_count <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_word  <= in_word;
                r_count <= w_popCount;
                if (in_word == 16'd0) begin
                    r_done <= 1'b1;
                end
            end else if (w_take) begin
                r_word <= w_clear;
                if (w_clear == 16'd0) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign out_idx   = w_lowIdx;
    assign bit_count = r_count;
    assign done      = r_done;

endmodule

// File: doc/mask_bit_scan16.md
# mask_bit_scan16

Sequential mask decoder that accepts a 16-bit mask word over a valid/ready handshake. It emits the index of every set bit, lowest first, one index per output handshake, and clears each reported bit with `word & (word - 1)`. It is the read side of the masked-logic datapath: the 16-bit AND unit builds masks, and this block enumerates them for per-bit sequencing, such as register-list and byte-enable walks.

## Interface
Parameters:
- None. Width is fixed at 16; index width is fixed at 4.

Ports:
- `clk`  in  1  single clock; every register updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  `in_word` is presented.
- `in_ready`  out  1  block can accept a word.
- `in_word`  in  16  mask to decode.
- `out_valid`  out  1  `out_idx` holds a pending set-bit index.
- `out_ready`  in  1  consumer takes `out_idx` this cycle.
- `out_idx`  out  4  index (0–15) of the lowest remaining set bit.
- `out_last`  out  1  `out_idx` is the final set bit of the current word.
- `bit_count`  out  5  popcount of the most recently accepted word (0–16).
- `done`  out  1  one-cycle pulse when a word is fully decoded.

## Operation
- Internal registers:
  - `word_q[15:0]`, the remaining mask.
  - `state`, either IDLE or SCAN.
  - `count_q[4:0]`.
  - `done_q`.
- IDLE:
  - `in_ready`=1 and `out_valid`=0.
  - Accept when `in_valid` && `in_ready`:
    - `word_q` <= `in_word`.
    - `count_q` <= popcount(`in_word`).
    - If `in_word` != 0, go to SCAN.
    - If `in_word` == 0, stay in IDLE and set `done_q` <= 1. No index is ever emitted for a zero word.
- SCAN:
  - `in_ready`=0 and `out_valid`=1.
  - `out_idx` = position of the least-significant 1 in `word_q`.
  - `out_last` = ((`word_q` & (`word_q` − 1)) == 0).
  - The clear term `word_q` & (`word_q` − 1) is a 16-bit AND of `word_q` with its 16-bit decrement. The decrement wraps mod 2^16 and never underflows in SCAN, because `word_q` != 0 there.
  - On `out_ready`=1:
    - `word_q` <= `word_q` & (`word_q` − 1).
    - If `out_last`: next state IDLE and `done_q` <= 1.
  - On `out_ready`=0, every output holds stable; the held value includes `out_idx` and `out_last`.
- `done` = `done_q`. `done_q` is cleared on every edge on which it is not being set, so it is always a single-cycle pulse.
- `bit_count` = `count_q`. It holds until the next accept, is not decremented while scanning, and outputs 16 for 0xFFFF.
- `in_ready` and `out_valid` are pure functions of `state`:
  - They are never both 1.
  - Neither depends combinationally on `in_valid` or `out_ready`.
- Inputs arriving in SCAN:
  - `in_valid` is ignored; `in_word` is not sampled.
  - The producer must hold `in_word` until `in_ready`.

## Timing
- Reset values, on the edge with `rst`=1:
  - `state`=IDLE, `word_q`=0, `count_q`=0, `done_q`=0.
  - Hence `in_ready`=1, `out_valid`=0, `out_idx`=0, `out_last`=0, `bit_count`=0, `done`=0.
- `rst` asserted mid-SCAN: on the next edge the block is in IDLE with all outputs at reset values.
  - No `done` pulse for the aborted word.
  - Remaining indices are discarded.
  - `rst` overrides a simultaneous accept or output handshake.
- Latency, word accepted at edge E:
  - `out_valid`=1 with the first index in the cycle after E.
  - `bit_count` updates in the cycle after E.
- Throughput is one index per cycle while `out_ready`=1. A word with k set bits occupies the block for exactly k cycles of SCAN.
- `done` is high the cycle after the final output handshake, or the cycle after a zero-word accept.
- `in_ready` returns to 1 in that same cycle, so the next word may be accepted while `done`=1.
  - The gap between the last index of one word and the first index of the next is one idle cycle.
  - `done` from the old word and the accept of the new word may coincide.
- Back-to-back zero words: `done` pulses on consecutive cycles.

## Test plan
- Reset mid-scan:
  - Stimulus: accept 0x8001, then assert `rst` in the first SCAN cycle.
  - Response: next cycle `out_valid`=0, `in_ready`=1, `bit_count`=0, `done`=0.
- Sparse word:
  - Stimulus: accept 0x8421 with `out_ready`=1.
  - Response: indices 0, 5, 10, 15 on four consecutive cycles.
  - `out_last`=1 only with 15; `bit_count`=4; `done` pulses once on the following cycle.
- Backpressure:
  - Stimulus: accept 0x0006 and hold `out_ready`=0 for 3 cycles.
  - Response: `out_idx`=1 and `out_last`=0 held stable for 3 cycles; after release, idx 1 then idx 2 (with `out_last`=1), then `done`.
- Zero word:
  - Stimulus: accept 0x0000.
  - Response: `out_valid` never asserts; `done`=1 the next cycle; `bit_count`=0; `in_ready` stays 1.
- Full word and back-to-back:
  - Stimulus: accept 0xFFFF, then present 0x0004 continuously.
  - Response: indices 0–15 over 16 cycles and `bit_count`=16.
  - 0x0004 is accepted in the `done` cycle, then idx 2 with `out_last`=1.
- Ignored input during SCAN:
  - Stimulus: toggle `in_valid` and `in_word` randomly while in SCAN on 0x0300.
  - Response: only indices 8 and 9 appear; no extra accept occurs.
